brush_line_raster: RTL and testbench

Parametrised line rasteriser for the drawing pipeline. Takes two endpoints and produces every pixel of the line, stamped with a run-time selectable square brush, as a stream of coordinates toward the frame-buffer writer. Replaces the fixed 3-pixel horizontal-brush line drawer. It adds Bresenham stepping in all octants, a square b×b brush, a valid/ready output handshake, abort, and optional off-screen clipping.

---
 rtl/brush_line_raster_pkg.sv | 34 +++
 rtl/brush_line_raster_stepper.sv | 97 +++++++++
 rtl/brush_line_raster.sv | 212 +++++++++++++++++++++
 tb/tb_brush_line_raster.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/brush_line_raster_pkg.sv
// Shared types and helpers for the brush line rasteriser.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Contents: FSM state enum, signed Bresenham width helper, brush clamp.
package brush_line_raster_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_STEP  = 2'd2,
    ST_BRUSH = 2'd3
  } state_t;

  // Extra bits on top of COORD_W for the signed dx/dy/err terms.
  localparam int ERR_EXTRA_W = 2;

  function automatic int err_w(input int coord_w);
    return coord_w + ERR_EXTRA_W;
  endfunction

  // A brush side of 0 means a single pixel; anything over bmax saturates.
  function automatic logic [3:0] clamp_brush(input logic [3:0] raw, input logic [3:0] bmax);
    logic [3:0] b;
    b = raw;
    if (raw == 4'd0) begin
      b = 4'd1;
    end else if (raw > bmax) begin
      b = bmax;
    end
    return b;
  endfunction

endpackage

// File: rtl/brush_line_raster_stepper.sv
// Bresenham centre stepper: walks centre (cx,cy) from (x0,y0) toward (x1,y1).
// Latency: load takes effect on the next edge; each advance moves one centre per edge.
// Backpressure: none of its own; the caller only pulses advance when a brush completes.
//
// Ports: clk/rst (async active-low), load_i (capture endpoints and derive dx/dy/err),
// advance_i (take one step), x0_i..y1_i (endpoints), cx_o/cy_o (current centre),
// nxt_cx_o/nxt_cy_o (centre after the next step), at_end_o (current centre is the last).
module bresenham_stepper
  import brush_line_raster_pkg::*;
#(
  parameter int COORD_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               advance_i,
  input  logic [COORD_W-1:0] x0_i,
  input  logic [COORD_W-1:0] y0_i,
  input  logic [COORD_W-1:0] x1_i,
  input  logic [COORD_W-1:0] y1_i,
  output logic [COORD_W-1:0] cx_o,
  output logic [COORD_W-1:0] cy_o,
  output logic [COORD_W-1:0] nxt_cx_o,
  output logic [COORD_W-1:0] nxt_cy_o,
  output logic               at_end_o
);

  localparam int SW = err_w(COORD_W);

  logic signed [SW-1:0]  dx_q, dy_q, err_q, err_d;
  logic                  sx_neg_q, sy_neg_q;
  logic [COORD_W-1:0]    cx_q, cy_q, rem_q;

  logic [COORD_W-1:0]    adx, ady;
  logic signed [SW-1:0]  ld_dx, ld_dy;
  logic signed [SW:0]    e2, dx_w, dy_w;
  logic                  step_x, step_y;
  logic [COORD_W-1:0]    cx_d, cy_d;

  always_comb begin
    adx   = (x1_i >= x0_i) ? (x1_i - x0_i) : (x0_i - x1_i);
    ady   = (y1_i >= y0_i) ? (y1_i - y0_i) : (y0_i - y1_i);
    ld_dx = $signed({{ERR_EXTRA_W{1'b0}}, adx});
    ld_dy = -$signed({{ERR_EXTRA_W{1'b0}}, ady});

    // Both decisions use the error value from before this step.
    e2     = {err_q, 1'b0};
    dx_w   = {dx_q[SW-1], dx_q};
    dy_w   = {dy_q[SW-1], dy_q};
    step_x = (e2 >= dy_w);
    step_y = (e2 <= dx_w);

    err_d = err_q;
    if (step_x) err_d = err_d + dy_q;
    if (step_y) err_d = err_d + dx_q;

    cx_d = cx_q;
    if (step_x) cx_d = sx_neg_q ? (cx_q - COORD_W'(1)) : (cx_q + COORD_W'(1));
    cy_d = cy_q;
    if (step_y) cy_d = sy_neg_q ? (cy_q - COORD_W'(1)) : (cy_q + COORD_W'(1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
      cx_q     <= '0;
      cy_q     <= '0;
      rem_q    <= '0;
    end else if (load_i) begin
      dx_q     <= ld_dx;
      dy_q     <= ld_dy;
      err_q    <= ld_dx + ld_dy;
      sx_neg_q <= (x1_i < x0_i);
      sy_neg_q <= (y1_i < y0_i);
      cx_q     <= x0_i;
      cy_q     <= y0_i;
      // Number of steps still to take: the major-axis length.
      rem_q    <= (adx >= ady) ? adx : ady;
    end else if (advance_i) begin
      err_q <= err_d;
      cx_q  <= cx_d;
      cy_q  <= cy_d;
      rem_q <= rem_q - COORD_W'(1);
    end
  end

  assign cx_o     = cx_q;
  assign cy_o     = cy_q;
  assign nxt_cx_o = cx_d;
  assign nxt_cy_o = cy_d;
  assign at_end_o = (rem_q == '0);

endmodule

// File: rtl/brush_line_raster.sv
// Line rasteriser: Bresenham centres stamped with a b x b square brush, streamed as pixels.
// Latency: i_start at edge N -> SETUP in N+1 -> first o_valid in N+2; then 1 pixel/cycle.
// Backpressure: valid/ready; pixel pointer holds while o_valid && !i_ready, o_valid never looks at i_ready.
//
// Ports: clk, rst (async active-low), i_start/i_x0/i_y0/i_x1/i_y1/i_brush (request, IDLE only),
// i_abort (drop line), o_valid/i_ready/o_x/o_y/o_last (pixel stream), o_busy, o_done (end pulse).
// Option: BRUSH_LINE_RASTER_CLIP_EN suppresses off-screen pixels instead of saturating them.
module brush_line_raster
  import brush_line_raster_pkg::*;
#(
  parameter int COORD_W   = 10,
  parameter int X_MAX     = 799,
  parameter int Y_MAX     = 599,
  parameter int BRUSH_MAX = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [COORD_W-1:0] i_x0,
  input  logic [COORD_W-1:0] i_y0,
  input  logic [COORD_W-1:0] i_x1,
  input  logic [COORD_W-1:0] i_y1,
  input  logic [3:0]         i_brush,
  input  logic               i_abort,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic               o_last,
  output logic               o_busy,
  output logic               o_done
);

  localparam logic [3:0]         BMAX = 4'(BRUSH_MAX);
  localparam logic [COORD_W:0]   XLIM = (COORD_W+1)'(X_MAX);
  localparam logic [COORD_W:0]   YLIM = (COORD_W+1)'(Y_MAX);

  state_t             state_q, state_d;
  logic [COORD_W-1:0] x0_q, y0_q, x1_q, y1_q;
  logic [COORD_W-1:0] x0_d, y0_d, x1_d, y1_d;
  logic [3:0]         b_q, b_d;
  logic [3:0]         i_q, i_d, j_q, j_d;
  logic               done_q, done_d;

  logic               stp_load, stp_adv;
  logic [COORD_W-1:0] cx, cy, nxt_cx, nxt_cy;
  logic               at_end;

  bresenham_stepper #(.COORD_W(COORD_W)) u_stepper (
    .clk       (clk),
    .rst       (rst),
    .load_i    (stp_load),
    .advance_i (stp_adv),
    .x0_i      (x0_q),
    .y0_i      (y0_q),
    .x1_i      (x1_q),
    .y1_i      (y1_q),
    .cx_o      (cx),
    .cy_o      (cy),
    .nxt_cx_o  (nxt_cx),
    .nxt_cy_o  (nxt_cy),
    .at_end_o  (at_end)
  );

  // Brush offsets are added one bit wider so off-screen sums never wrap.
  logic [3:0]         bm1;
  logic               in_brush, row_end, col_end, brush_end;
  logic [COORD_W:0]   sum_x, sum_y;
  logic [COORD_W-1:0] pix_x, pix_y;
  logic               pix_vld, pix_last, pix_adv;

  assign bm1       = b_q - 4'd1;
  assign in_brush  = (state_q == ST_BRUSH);
  assign row_end   = (i_q == bm1);
  assign col_end   = (j_q == bm1);
  assign brush_end = row_end && col_end;
  assign sum_x     = {1'b0, cx} + (COORD_W+1)'(i_q);
  assign sum_y     = {1'b0, cy} + (COORD_W+1)'(j_q);

`ifdef BRUSH_LINE_RASTER_CLIP_EN
  localparam logic [COORD_W-1:0] XC = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] YC = COORD_W'(Y_MAX);

  logic pix_vis, more_x, more_y, nxt_vis;

  // The visible centres of a line form one contiguous run (x and y are each
  // monotonic), so a visible pixel is the last visible one exactly when nothing
  // later in its own brush is on screen and the following centre is off screen.
  always_comb begin
    pix_vis  = (sum_x <= XLIM) && (sum_y <= YLIM);
    more_x   = !row_end && (sum_x < XLIM);
    more_y   = !col_end && (sum_y < YLIM);
    nxt_vis  = (nxt_cx <= XC) && (nxt_cy <= YC);
    pix_x    = sum_x[COORD_W-1:0];
    pix_y    = sum_y[COORD_W-1:0];
    pix_vld  = in_brush && pix_vis;
    pix_last = pix_vld && !more_x && !more_y && (at_end || !nxt_vis);
    // A suppressed pixel still burns its cycle but needs no handshake.
    pix_adv  = in_brush && (!pix_vis || i_ready);
  end
`else
  localparam logic [COORD_W-1:0] XSAT = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] YSAT = COORD_W'(Y_MAX);

  logic unused_nxt;
  assign unused_nxt = ^{nxt_cx, nxt_cy};

  always_comb begin
    pix_x    = (sum_x > XLIM) ? XSAT : sum_x[COORD_W-1:0];
    pix_y    = (sum_y > YLIM) ? YSAT : sum_y[COORD_W-1:0];
    pix_vld  = in_brush;
    pix_last = in_brush && brush_end && at_end;
    pix_adv  = in_brush && i_ready;
  end
`endif

  always_comb begin
    state_d  = state_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    x1_d     = x1_q;
    y1_d     = y1_q;
    b_d      = b_q;
    i_d      = i_q;
    j_d      = j_q;
    done_d   = 1'b0;
    stp_load = 1'b0;
    stp_adv  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_start && !i_abort) begin
          x0_d    = i_x0;
          y0_d    = i_y0;
          x1_d    = i_x1;
          y1_d    = i_y1;
          b_d     = clamp_brush(i_brush, BMAX);
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (i_abort) begin
          state_d = ST_IDLE;
        end else begin
          stp_load = 1'b1;
          i_d      = 4'd0;
          j_d      = 4'd0;
          state_d  = ST_BRUSH;
        end
      end
      ST_BRUSH: begin
        if (i_abort) begin
          state_d = ST_IDLE;
        end else if (pix_adv) begin
          if (!row_end) begin
            i_d = i_q + 4'd1;
          end else begin
            i_d = 4'd0;
            if (!col_end) begin
              j_d = j_q + 4'd1;
            end else begin
              j_d = 4'd0;
              // Centre step rides on the last brush pixel, so brushes run back to back.
              if (at_end) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end else begin
                stp_adv = 1'b1;
              end
            end
          end
        end
      end
      // Stepping is folded into ST_BRUSH; this encoding is never entered.
      ST_STEP: state_d = i_abort ? ST_IDLE : ST_BRUSH;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      b_q     <= 4'd1;
      i_q     <= 4'd0;
      j_q     <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      b_q     <= b_d;
      i_q     <= i_d;
      j_q     <= j_d;
      done_q  <= done_d;
    end
  end

  // Outputs decode registered state only; coordinates read 0 outside BRUSH.
  assign o_valid = pix_vld;
  assign o_x     = in_brush ? pix_x : '0;
  assign o_y     = in_brush ? pix_y : '0;
  assign o_last  = pix_last;
  assign o_busy  = (state_q != ST_IDLE);
  assign o_done  = done_q;

endmodule

// File: tb/tb_brush_line_raster.sv
module tb_brush_line_raster;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_start, i_abort, i_ready;
  logic [W-1:0] i_x0, i_y0, i_x1, i_y1;
  logic [3:0]   i_brush;
  logic         o_valid, o_last, o_busy, o_done;
  logic [W-1:0] o_x, o_y;

  always #5 clk = ~clk;

  brush_line_raster #(.COORD_W(W), .X_MAX(799), .Y_MAX(599), .BRUSH_MAX(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_start (i_start),
    .i_x0    (i_x0),
    .i_y0    (i_y0),
    .i_x1    (i_x1),
    .i_y1    (i_y1),
    .i_brush (i_brush),
    .i_abort (i_abort),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_x     (o_x),
    .o_y     (o_y),
    .o_last  (o_last),
    .o_busy  (o_busy),
    .o_done  (o_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Observation of one line run.
  int obs_x[$], obs_y[$], obs_last[$];
  int first_vld, done_cyc, last_xfer, stall_err, timed_out, last_cnt, busy_bad;
  // Reference pixels.
  int exp_x[$], exp_y[$];

  // Reference: textbook Bresenham that stops on reaching the endpoint,
  // square brush stamped on each centre, then screen-edge handling.
  task automatic model_line(input int x0, input int y0, input int x1, input int y1, input int braw);
    int b, dx, dy, sx, sy, err, e2, x, y, px, py;
    exp_x.delete();
    exp_y.delete();
    b  = (braw == 0) ? 1 : ((braw > 8) ? 8 : braw);
    dx = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy = -((y1 > y0) ? y1 - y0 : y0 - y1);
    sx = (x0 < x1) ? 1 : -1;
    sy = (y0 < y1) ? 1 : -1;
    err = dx + dy;
    x = x0;
    y = y0;
    forever begin
      for (int j = 0; j < b; j++) begin
        for (int i = 0; i < b; i++) begin
          px = x + i;
          py = y + j;
`ifdef BRUSH_LINE_RASTER_CLIP_EN
          if (px <= 799 && py <= 599) begin
            exp_x.push_back(px);
            exp_y.push_back(py);
          end
`else
          exp_x.push_back((px > 799) ? 799 : px);
          exp_y.push_back((py > 599) ? 599 : py);
`endif
        end
      end
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  // Issue one line and record every transfer until o_done or the cycle budget.
  task automatic run_line(input int x0, input int y0, input int x1, input int y1, input int b,
                          input int ready_pct, input int budget, input bit poke_start);
    bit prev_stall;
    int px, py, pl;
    obs_x.delete(); obs_y.delete(); obs_last.delete();
    first_vld = -1; done_cyc = -1; last_xfer = -1;
    stall_err = 0; timed_out = 0; last_cnt = 0; busy_bad = 0;
    prev_stall = 0; px = 0; py = 0; pl = 0;
    @(posedge clk); #1;
    i_x0 = W'(x0); i_y0 = W'(y0); i_x1 = W'(x1); i_y1 = W'(y1);
    i_brush = 4'(b);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      i_ready = ($urandom_range(99) < ready_pct);
      if (poke_start && k == 5) begin
        i_start = 1'b1;
        i_x0 = W'(300); i_y0 = W'(300); i_x1 = W'(310); i_y1 = W'(305); i_brush = 4'd5;
      end else begin
        i_start = 1'b0;
      end
      @(negedge clk);
      if (prev_stall && (!o_valid || o_x != W'(px) || o_y != W'(py) || int'(o_last) != pl))
        stall_err++;
      if (o_valid && first_vld < 0) first_vld = k;
      if (o_done) begin
        done_cyc = k;
        if (o_busy) busy_bad = 1;
        break;
      end
      prev_stall = o_valid && !i_ready;
      px = int'(o_x); py = int'(o_y); pl = int'(o_last);
      if (o_valid && i_ready) begin
        obs_x.push_back(int'(o_x));
        obs_y.push_back(int'(o_y));
        obs_last.push_back(int'(o_last));
        if (o_last) begin last_cnt++; last_xfer = k; end
      end
      @(posedge clk); #1;
    end
    i_start = 1'b0;
    if (done_cyc < 0) begin
      timed_out = 1;
      i_abort = 1'b1;
      @(posedge clk); #1;
      i_abort = 1'b0;
    end else begin
      @(posedge clk); #1;
    end
    i_ready = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    n_checks++;
    if ({o_valid, o_x, o_y, o_last, o_busy, o_done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%0b x=%0d y=%0d last=%0b busy=%0b done=%0b, need all 0",
               o_valid, o_x, o_y, o_last, o_busy, o_done);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_horizontal;
    int bad;
    run_line(10, 20, 13, 20, 1, 100, 60, 0);
    n_checks++;
    if (timed_out != 0) begin n_fail++; $display("FAIL horiz_timeout: got no o_done within budget, need o_done"); end
    n_checks++;
    if (first_vld != 2) begin n_fail++; $display("FAIL horiz_first_valid: got cycle %0d, need 2", first_vld); end
    bad = (obs_x.size() != 4);
    if (!bad) for (int k = 0; k < 4; k++) if (obs_x[k] != 10 + k || obs_y[k] != 20) bad = 1;
    n_checks++;
    if (bad) begin n_fail++; $display("FAIL horiz_pixels: got %0d pixels, need x=10..13 y=20 (4 pixels)", obs_x.size()); end
    n_checks++;
    if (!(last_cnt == 1 && obs_last.size() == 4 && obs_last[3] == 1)) begin
      n_fail++; $display("FAIL horiz_last: got %0d last flags, need 1 on 4th pixel", last_cnt);
    end
    n_checks++;
    if (done_cyc != last_xfer + 1 || busy_bad != 0) begin
      n_fail++; $display("FAIL horiz_done: got done at %0d (last xfer %0d, busy_bad %0d), need last+1 with busy 0",
                         done_cyc, last_xfer, busy_bad);
    end
  endtask

  // Case 2 constant list, shared by the diagonal and backpressure scenarios.
  task automatic load_diag_expected;
    int ex[12] = '{0, 1, 0, 1, 1, 2, 1, 2, 2, 3, 2, 3};
    int ey[12] = '{0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3};
    exp_x.delete(); exp_y.delete();
    for (int k = 0; k < 12; k++) begin exp_x.push_back(ex[k]); exp_y.push_back(ey[k]); end
  endtask

  task automatic test_diagonal;
    int bad;
    load_diag_expected();
    run_line(0, 0, 2, 2, 2, 100, 80, 0);
    bad = (obs_x.size() != exp_x.size()) || timed_out;
    if (!bad) foreach (exp_x[k]) if (obs_x[k] != exp_x[k] || obs_y[k] != exp_y[k]) bad = 1;
    n_checks++;
    if (bad) begin n_fail++; $display("FAIL diag_seq: got %0d pixels (timeout %0d), need 12 listed pixels", obs_x.size(), timed_out); end
    n_checks++;
    if (last_cnt != 1 || obs_last.size() != 12 || obs_last[11] != 1) begin
      n_fail++; $display("FAIL diag_last: got %0d last flags, need 1 on pixel 12", last_cnt);
    end
  endtask

  task automatic test_steep;
    int bad;
    run_line(5, 9, 3, 3, 1, 100, 60, 0);
    bad = (obs_y.size() != 7) || timed_out;
    if (!bad) for (int k = 0; k < 7; k++) if (obs_y[k] != 9 - k) bad = 1;
    n_checks++;
    if (bad) begin n_fail++; $display("FAIL steep_y: got %0d pixels, need 7 with y 9 down to 3", obs_y.size()); end
    n_checks++;
    if (obs_x.size() == 0 || obs_x[$] != 3 || obs_y[$] != 3) begin
      n_fail++; $display("FAIL steep_final: got (%0d,%0d), need (3,3)",
                         (obs_x.size() != 0) ? obs_x[$] : -1, (obs_y.size() != 0) ? obs_y[$] : -1);
    end
    model_line(5, 9, 3, 3, 1);
    bad = (obs_x.size() != exp_x.size());
    if (!bad) foreach (exp_x[k]) if (obs_x[k] != exp_x[k] || obs_y[k] != exp_y[k]) bad = 1;
    n_checks++;
    if (bad) begin n_fail++; $display("FAIL steep_model: got %0d pixels, need %0d matching model", obs_x.size(), exp_x.size()); end
  endtask

  task automatic test_backpressure;
    int bad;
    load_diag_expected();
    run_line(0, 0, 2, 2, 2, 50, 200, 1);
    bad = (obs_x.size() != exp_x.size()) || timed_out;
    if (!bad) foreach (exp_x[k]) if (obs_x[k] != exp_x[k] || obs_y[k] != exp_y[k]) bad = 1;
    n_checks++;
    if (bad) begin n_fail++; $display("FAIL bp_seq: got %0d pixels (timeout %0d), need 12 listed pixels", obs_x.size(), timed_out); end
    n_checks++;
    if (stall_err != 0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable stall cycles, need 0", stall_err); end
    n_checks++;
    if (o_busy !== 1'b0) begin n_fail++; $display("FAIL bp_ignored_start: got busy=%0b after line, need 0", o_busy); end
  endtask

  task automatic test_screen_edge;
    int bad;
    model_line(798, 599, 799, 599, 3);
    run_line(798, 599, 799, 599, 3, 100, 80, 0);
`ifdef BRUSH_LINE_RASTER_CLIP_EN
    n_checks++;
    if (obs_x.size() != 3) begin n_fail++; $display("FAIL edge_count: got %0d pixels, need 3", obs_x.size()); end
`else
    n_checks++;
    if (obs_x.size() != 18) begin n_fail++; $display("FAIL edge_count: got %0d pixels, need 18", obs_x.size()); end
`endif
    bad = 0;
    foreach (obs_x[k]) if (obs_x[k] > 799 || obs_y[k] != 599) bad = 1;
    n_checks++;
    if (bad) begin n_fail++; $display("FAIL edge_range: got a pixel outside x<=799,y=599, need none"); end
    bad = (obs_x.size() != exp_x.size()) || timed_out;
    if (!bad) foreach (exp_x[k]) if (obs_x[k] != exp_x[k] || obs_y[k] != exp_y[k]) bad = 1;
    n_checks++;
    if (bad) begin n_fail++; $display("FAIL edge_model: got %0d pixels, need %0d matching model", obs_x.size(), exp_x.size()); end
    n_checks++;
    if (last_cnt != 1 || obs_last[$] != 1) begin n_fail++; $display("FAIL edge_last: got %0d last flags, need 1 on final", last_cnt); end
  endtask

  task automatic test_abort;
    int xf, hit, seen;
    @(posedge clk); #1;
    i_x0 = 0; i_y0 = 0; i_x1 = 2; i_y1 = 2; i_brush = 4'd2; i_start = 1'b1; i_ready = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    xf = 0; hit = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_valid && xf == 2) begin i_abort = 1'b1; hit = 1; break; end
      if (o_valid && i_ready) xf++;
    end
    n_checks++;
    if (hit != 1) begin n_fail++; $display("FAIL abort_reach: got %0d transfers before budget, need 3rd pixel shown", xf); end
    @(posedge clk); #1;
    i_abort = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({o_valid, o_busy, o_last, o_done} !== 4'b0000) begin
      n_fail++; $display("FAIL abort_drop: got v=%0b busy=%0b last=%0b done=%0b, need all 0", o_valid, o_busy, o_last, o_done);
    end
    seen = 0;
    for (int k = 0; k < 8; k++) begin @(negedge clk); if (o_done || o_valid) seen = 1; end
    n_checks++;
    if (seen != 0) begin n_fail++; $display("FAIL abort_quiet: got o_done/o_valid after abort, need none"); end
    i_ready = 1'b0;
    // Abort and start together in IDLE: nothing starts.
    @(posedge clk); #1;
    i_start = 1'b1; i_abort = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0; i_abort = 1'b0;
    @(negedge clk);
    n_checks++;
    if (o_busy !== 1'b0) begin n_fail++; $display("FAIL abort_start_idle: got busy=%0b, need 0", o_busy); end
  endtask

  task automatic test_reset_midline;
    int bad;
    @(posedge clk); #1;
    i_x0 = 0; i_y0 = 0; i_x1 = 2; i_y1 = 2; i_brush = 4'd2; i_start = 1'b1; i_ready = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (o_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid: got o_valid=%0b mid-line, need 1", o_valid); end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({o_valid, o_x, o_y, o_last, o_busy, o_done} !== '0) begin
      n_fail++; $display("FAIL rst_midline: got v=%0b x=%0d y=%0d last=%0b busy=%0b done=%0b, need all 0",
                         o_valid, o_x, o_y, o_last, o_busy, o_done);
    end
    i_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_line(10, 20, 13, 20, 1);
    run_line(10, 20, 13, 20, 1, 100, 60, 0);
    bad = (obs_x.size() != exp_x.size()) || timed_out;
    if (!bad) foreach (exp_x[k]) if (obs_x[k] != exp_x[k] || obs_y[k] != exp_y[k]) bad = 1;
    n_checks++;
    if (bad || first_vld != 2) begin
      n_fail++; $display("FAIL rst_restart: got %0d pixels first valid %0d, need 4 pixels first valid 2", obs_x.size(), first_vld);
    end
  endtask

  task automatic test_random;
    int x0, y0, x1, y1, b, bc, span, bad, budget;
    for (int n = 0; n < 12; n++) begin
      if ($urandom_range(1) == 0) begin
        x0 = int'($urandom_range(20)); y0 = int'($urandom_range(20));
      end else begin
        x0 = int'($urandom_range(805, 790)); y0 = int'($urandom_range(605, 590));
      end
      x1 = x0 + int'($urandom_range(12)) - 6;
      y1 = y0 + int'($urandom_range(12)) - 6;
      if (x1 < 0) x1 = 0;
      if (y1 < 0) y1 = 0;
      b  = int'($urandom_range(15));
      bc = (b == 0) ? 1 : ((b > 8) ? 8 : b);
      span = ((x1 > x0) ? x1 - x0 : x0 - x1);
      if (((y1 > y0) ? y1 - y0 : y0 - y1) > span) span = (y1 > y0) ? y1 - y0 : y0 - y1;
      budget = 4 * (span + 1) * bc * bc + 50;
      model_line(x0, y0, x1, y1, b);
      run_line(x0, y0, x1, y1, b, 70, budget, 0);
      bad = (obs_x.size() != exp_x.size()) || timed_out;
      if (!bad) foreach (exp_x[k]) if (obs_x[k] != exp_x[k] || obs_y[k] != exp_y[k]) bad = 1;
      n_checks++;
      if (bad) begin
        n_fail++;
        $display("FAIL rand_seq line %0d (%0d,%0d)->(%0d,%0d) b=%0d: got %0d pixels timeout=%0d, need %0d matching model",
                 n, x0, y0, x1, y1, b, obs_x.size(), timed_out, exp_x.size());
      end
      n_checks++;
      if (last_cnt != ((exp_x.size() > 0) ? 1 : 0) || (obs_last.size() > 0 && obs_last[$] != 1) || stall_err != 0) begin
        n_fail++;
        $display("FAIL rand_last line %0d: got %0d last flags, %0d stall errors, need %0d and 0",
                 n, last_cnt, stall_err, (exp_x.size() > 0) ? 1 : 0);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    i_start = 1'b0; i_abort = 1'b0; i_ready = 1'b0;
    i_x0 = '0; i_y0 = '0; i_x1 = '0; i_y1 = '0; i_brush = '0;
    test_reset();
    test_horizontal();
    test_diagonal();
    test_steep();
    test_backpressure();
    test_screen_edge();
    test_abort();
    test_reset_midline();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time limit, need completion");
    $fatal(1, "watchdog expired");
  end

endmodule
